instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Instruction fetch stage of the 5-stage pipelined processor, sitting directly upstream of the decode stage. It owns the program counter, drives a combinational-read instruction memory port, and resolves `j` in IF with no bubble. It applies EX-stage branch redirects and hazard-unit stalls, and registers the fetched word into the IF/ID pipeline register. The register's field outputs feed the decoder's register-address, `rd`, immediate and `jump_in` inputs.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- JUMP_OPCODE, 6'b000010, opcode resolved as an unconditional jump in IF.

- clk  input  1  pipeline clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- stall  input  1  from hazard unit; hold PC and IF/ID.
- branch_taken  input  1  from EX; redirect fetch and flush IF/ID.
- branch_target  input  32  redirect address from EX; bits [1:0] ignored (treated as 0).
- imem_addr  output  32  current PC to instruction memory; equals pc.
- imem_rdata  input  32  instruction word, combinational from imem_addr.
- pc  output  32  current fetch PC.
- if_id_instr  output  32  registered instruction word.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction; 0 = bubble.
- rs_out, rt_out, rd_out  output  5 each  instr [25:21], [20:16], [15:11] of if_id_instr.
- imm_out  output  16  instr [15:0] of if_id_instr.
- jump_out  output  1  registered: IF/ID instruction is a jump and valid.
- fetch_count  output  32  instructions accepted into IF/ID; wraps modulo 2^32.
- flush_count  output  32  IF/ID flushes caused by branch_taken; wraps modulo 2^32.

## Operation
- Field outputs are pure slices of if_id_instr; no extra register stage.
- Next-PC priority:
  - branch_taken → {branch_target[31:2], 2'b00}.
  - else stall → pc (hold).
  - else imem_rdata[31:26] == JUMP_OPCODE → {pc_plus4[31:28], imem_rdata[25:0], 2'b00}.
  - else pc + 4.
- pc_plus4 = pc + 4; 32-bit addition, wraps from 32'hFFFF_FFFC to 0 with no flag.
- IF/ID update, same priority:
  - branch_taken → if_id_instr = 0, if_id_pc_plus4 = 0, if_id_valid = 0, jump_out = 0; flush_count += 1.
  - else stall → all IF/ID state held; counters held.
  - else → load imem_rdata, pc_plus4, valid = 1, jump_out = jump detect; fetch_count += 1.
- An IF-resolved jump is still passed into IF/ID so decode sees jump_in; the slot after it is the jump target, not PC+4.
- branch_taken together with stall: branch wins, PC redirects and IF/ID flushes. The hazard unit's stall is ignored that cycle.
- branch_taken while the IF word is a jump: the jump is discarded and PC goes to branch_target.
- Reset asserted mid-operation, asynchronously:
  - pc = RESET_PC.
  - All IF/ID state = 0, if_id_valid = 0, jump_out = 0.
  - Both counters = 0.
- After reset deasserts, the first rising edge loads the instruction at RESET_PC into IF/ID.

## Timing
- imem_addr = pc combinationally; imem_rdata is sampled at the same rising edge (zero-wait memory).
- Fetch-to-IF/ID latency: 1 cycle.
- Jump penalty: 0 cycles. Target is fetched on the edge after the jump is fetched.
- Branch penalty: the flushed IF/ID slot plus whatever the downstream stages flush. This block flushes only IF/ID.
- stall held for N cycles freezes pc and IF/ID for exactly N edges. No instruction is lost or duplicated.
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, all other outputs 0.

## Test plan
- Sequential fetch: reset release with RESET_PC = 0 and memory holding distinct words → pc 0, 4, 8, 12 on successive edges; if_id_pc_plus4 = 4, 8, 12; fetch_count = 3 after 3 edges.
- Jump: word 32'h0800_0040 at 0x8 → pc goes 0x8 → 0x100 on the next edge; IF/ID holds the jump with jump_out = 1; the following slot holds mem[0x100].
- Stall: assert stall 3 cycles at pc = 0x10 → pc stays 0x10 and IF/ID is unchanged for 3 edges; fetch_count does not advance; fetch resumes at 0x14.
- Branch + stall: branch_taken = 1, stall = 1, branch_target = 32'h0000_0203 → pc = 0x200; if_id_valid = 0; if_id_instr = 0; flush_count = 1.
- Async reset mid-run: drop reset between edges at pc = 0x24 → pc = RESET_PC and outputs/counters = 0 immediately, before the next edge.
- Wrap: RESET_PC = 32'hFFFF_FFFC → next pc = 0; if_id_pc_plus4 = 0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the fetch stage's control, instruction-memory and IF/ID signals.
//
// Handshake semantics: there is no valid/ready pair on this bus. The memory
// port has zero wait states: imem_addr is presented combinationally and
// imem_rdata must be valid before the same rising edge. stall and
// branch_taken are level-sampled on every rising edge. if_id_valid marks
// whether the IF/ID register holds a real instruction (1) or a bubble (0).
interface instruction_fetch_unit_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic [4:0]  rs_out;
   logic [4:0]  rt_out;
   logic [4:0]  rd_out;
   logic [15:0] imm_out;
   logic        jump_out;
   logic [31:0] fetch_count;
   logic [31:0] flush_count;

   // Environment side: hazard unit, EX stage, instruction memory, decode.
   modport master (
      output stall, branch_taken, branch_target, imem_rdata,
      input  imem_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
             rs_out, rt_out, rd_out, imm_out, jump_out,
             fetch_count, flush_count
   );

   // Fetch unit side.
   modport slave (
      input  stall, branch_taken, branch_target, imem_rdata,
      output imem_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
             rs_out, rt_out, rd_out, imm_out, jump_out,
             fetch_count, flush_count
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, resolves unconditional jumps in IF
// with no bubble, applies EX branch redirects and hazard stalls, and
// registers the fetched word into the IF/ID pipeline register.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [5:0]  JUMP_OPCODE = 6'b000010
) (
   input logic                     clk,
   input logic                     reset,
   instruction_fetch_unit_if.slave bus
);

   // What happens to PC and IF/ID on the coming edge. Branch outranks
   // stall, which outranks a normal load.
   typedef enum logic [1:0] {
      ACT_LOAD  = 2'd0,
      ACT_HOLD  = 2'd1,
      ACT_FLUSH = 2'd2
   } action_e;

   action_e     action;
   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] next_pc;
   logic        is_jump;

   logic [31:0] if_id_instr_q;
   logic [31:0] if_id_pc_plus4_q;
   logic        if_id_valid_q;
   logic        jump_q;
   logic [31:0] fetch_count_q;
   logic [31:0] flush_count_q;

   // The low two bits of a redirect address are forced to zero.
   logic unused_target_lsbs;
   assign unused_target_lsbs = ^bus.branch_target[1:0];

   assign pc_plus4    = pc_q + 32'd4;
   assign is_jump     = (bus.imem_rdata[31:26] == JUMP_OPCODE);
   assign jump_target = {pc_plus4[31:28], bus.imem_rdata[25:0], 2'b00};

   // Select this cycle's action from the redirect and stall inputs.
   always_comb begin
      action = ACT_LOAD;
      if (bus.branch_taken) begin
         action = ACT_FLUSH;
      end else if (bus.stall) begin
         action = ACT_HOLD;
      end
   end

   // Next PC: branch redirect, hold, IF-resolved jump, or sequential.
   always_comb begin
      next_pc = pc_plus4;
      case (action)
         ACT_FLUSH: next_pc = {bus.branch_target[31:2], 2'b00};
         ACT_HOLD:  next_pc = pc_q;
         default:   next_pc = is_jump ? jump_target : pc_plus4;
      endcase
   end

   // Program counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= next_pc;
      end
   end

   // IF/ID register and its fetch/flush counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_id_instr_q    <= 32'd0;
         if_id_pc_plus4_q <= 32'd0;
         if_id_valid_q    <= 1'b0;
         jump_q           <= 1'b0;
         fetch_count_q    <= 32'd0;
         flush_count_q    <= 32'd0;
      end else begin
         case (action)
            ACT_FLUSH: begin
               if_id_instr_q    <= 32'd0;
               if_id_pc_plus4_q <= 32'd0;
               if_id_valid_q    <= 1'b0;
               jump_q           <= 1'b0;
               flush_count_q    <= flush_count_q + 32'd1;
            end
            ACT_LOAD: begin
               if_id_instr_q    <= bus.imem_rdata;
               if_id_pc_plus4_q <= pc_plus4;
               if_id_valid_q    <= 1'b1;
               jump_q           <= is_jump;
               fetch_count_q    <= fetch_count_q + 32'd1;
            end
            default: begin
               if_id_instr_q    <= if_id_instr_q;
               if_id_pc_plus4_q <= if_id_pc_plus4_q;
               if_id_valid_q    <= if_id_valid_q;
               jump_q           <= jump_q;
               fetch_count_q    <= fetch_count_q;
               flush_count_q    <= flush_count_q;
            end
         endcase
      end
   end

   // Output drive; decoder fields are plain slices of the IF/ID word.
   assign bus.pc             = pc_q;
   assign bus.imem_addr      = pc_q;
   assign bus.if_id_instr    = if_id_instr_q;
   assign bus.if_id_pc_plus4 = if_id_pc_plus4_q;
   assign bus.if_id_valid    = if_id_valid_q;
   assign bus.jump_out       = jump_q;
   assign bus.rs_out         = if_id_instr_q[25:21];
   assign bus.rt_out         = if_id_instr_q[20:16];
   assign bus.rd_out         = if_id_instr_q[15:11];
   assign bus.imm_out        = if_id_instr_q[15:0];
   assign bus.fetch_count    = fetch_count_q;
   assign bus.flush_count    = flush_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// stall/branch traffic, checked against a behavioural reference model.
module tb_instruction_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [31:0] fcnt;
      logic [31:0] flcnt;
      logic        valid;
      logic        jump;
   } exp_t;

   localparam logic [31:0] WRAP_WORD = 32'h2001_0005;

   logic clk;
   logic reset;
   logic reset2;

   instruction_fetch_unit_if bus ();
   instruction_fetch_unit_if bus2 ();

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset2), .bus(bus2)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [31:0] mem [0:255];
   assign bus.imem_rdata  = mem[bus.imem_addr[9:2]];
   assign bus2.imem_rdata = WRAP_WORD;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem[8'((a >> 2) & 32'hFF)];
   endfunction

   function automatic logic [31:0] plain_word();
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] == 6'b000010) w[31:26] = 6'h23;
      return w;
   endfunction

   // ---------------- scoreboard state ----------------
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model of the architectural state after each edge.
   logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_flcnt;
   logic        m_valid, m_jump;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
      m_fcnt = 32'd0; m_flcnt = 32'd0; m_valid = 1'b0; m_jump = 1'b0;
   endtask

   task automatic chk_reset_state();
      chk("rst_pc", bus.pc, 32'd0);
      chk("rst_imem_addr", bus.imem_addr, 32'd0);
      chk("rst_instr", bus.if_id_instr, 32'd0);
      chk("rst_pc4", bus.if_id_pc_plus4, 32'd0);
      chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
      chk("rst_jump", {31'd0, bus.jump_out}, 32'd0);
      chk("rst_fields", {bus.rs_out, bus.rt_out, bus.rd_out, bus.imm_out[0]}, 32'd0);
      chk("rst_fetch_count", bus.fetch_count, 32'd0);
      chk("rst_flush_count", bus.flush_count, 32'd0);
   endtask

   // ---------------- driver ----------------
   // Drives one cycle of control inputs, advances the model, pushes the
   // expected post-edge state, then waits past the edge and the monitor.
   task automatic step(input logic s, input logic b, input logic [31:0] t);
      logic [31:0] w, p4;
      exp_t e;
      bus.stall = s;
      bus.branch_taken = b;
      bus.branch_target = t;
      w  = mem_word(m_pc);
      p4 = m_pc + 32'd4;
      if (b) begin
         m_pc = t & 32'hFFFF_FFFC;
         m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_jump = 1'b0;
         m_flcnt = m_flcnt + 32'd1;
      end else if (!s) begin
         m_jump  = (w[31:26] == 6'b000010);
         m_instr = w;
         m_pc4   = p4;
         m_valid = 1'b1;
         m_fcnt  = m_fcnt + 32'd1;
         m_pc    = m_jump ? {p4[31:28], w[25:0], 2'b00} : p4;
      end
      e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.fcnt = m_fcnt;
      e.flcnt = m_flcnt; e.valid = m_valid; e.jump = m_jump;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Holds reset for one edge, then releases it away from the edge.
   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pc", bus.pc, e.pc);
         chk("imem_addr", bus.imem_addr, e.pc);
         chk("if_id_instr", bus.if_id_instr, e.instr);
         chk("if_id_pc_plus4", bus.if_id_pc_plus4, e.pc4);
         chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
         chk("jump_out", {31'd0, bus.jump_out}, {31'd0, e.jump});
         chk("rs_out", {27'd0, bus.rs_out}, {27'd0, e.instr[25:21]});
         chk("rt_out", {27'd0, bus.rt_out}, {27'd0, e.instr[20:16]});
         chk("rd_out", {27'd0, bus.rd_out}, {27'd0, e.instr[15:11]});
         chk("imm_out", {16'd0, bus.imm_out}, {16'd0, e.instr[15:0]});
         chk("fetch_count", bus.fetch_count, e.fcnt);
         chk("flush_count", bus.flush_count, e.flcnt);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] w3;
      reset = 1'b0;
      reset2 = 1'b0;
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_target = 32'd0;
      bus2.stall = 1'b0;
      bus2.branch_taken = 1'b0;
      bus2.branch_target = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = plain_word();
      model_reset();
      #3;
      chk_reset_state();

      // Sequential fetch from RESET_PC.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);
      chk("seq_pc", bus.pc, 32'd12);
      chk("seq_pc4", bus.if_id_pc_plus4, 32'd12);
      chk("seq_fetch_count", bus.fetch_count, 32'd3);

      // Stall for three cycles at pc 0x10.
      step(1'b0, 1'b0, 32'd0);
      chk("pre_stall_pc", bus.pc, 32'h10);
      w3 = mem[3];
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'd0);
         chk("stall_pc", bus.pc, 32'h10);
         chk("stall_instr", bus.if_id_instr, w3);
         chk("stall_fetch_count", bus.fetch_count, 32'd4);
      end
      step(1'b0, 1'b0, 32'd0);
      chk("resume_pc", bus.pc, 32'h14);
      chk("resume_instr", bus.if_id_instr, mem[4]);
      chk("resume_fetch_count", bus.fetch_count, 32'd5);

      // Run to 0x24, then reset asynchronously between edges.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
      chk("pre_reset_pc", bus.pc, 32'h24);
      #1;
      reset = 1'b0;
      #1;
      chk_reset_state();

      // Jump resolved in IF with no bubble.
      mem[2] = 32'h0800_0040;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);
      chk("jump_pc", bus.pc, 32'h100);
      chk("jump_instr", bus.if_id_instr, 32'h0800_0040);
      chk("jump_out_set", {31'd0, bus.jump_out}, 32'd1);
      step(1'b0, 1'b0, 32'd0);
      chk("jump_slot_instr", bus.if_id_instr, mem[64]);
      chk("jump_slot_pc", bus.pc, 32'h104);

      // Branch together with stall: branch wins.
      step(1'b1, 1'b1, 32'h0000_0203);
      chk("br_stall_pc", bus.pc, 32'h200);
      chk("br_stall_valid", {31'd0, bus.if_id_valid}, 32'd0);
      chk("br_stall_instr", bus.if_id_instr, 32'd0);
      chk("br_stall_flush_count", bus.flush_count, 32'd1);

      // Random traffic over a memory seeded with short-range jumps.
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = plain_word();
         if ($urandom_range(0, 7) == 0)
            mem[i] = {6'b000010, 18'd0, 8'($urandom_range(0, 255))};
      end
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
              32'($urandom_range(0, 1023)));
      end
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;

      // PC wrap from 0xFFFF_FFFC on the second instance.
      @(posedge clk);
      #2;
      reset2 = 1'b1;
      @(posedge clk);
      #1;
      chk("wrap_pc", bus2.pc, 32'd0);
      chk("wrap_pc4", bus2.if_id_pc_plus4, 32'd0);
      chk("wrap_instr", bus2.if_id_instr, WRAP_WORD);
      chk("wrap_valid", {31'd0, bus2.if_id_valid}, 32'd1);

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
